note_scroller: RTL

- Producer side of the hit-judge interface. Holds one 8-row falling-note lane, advances it on an internal step tick and accepts new notes from the chart sequencer.
- Tells the judge which colour the lowest (oldest) note is and which row it sits in (offset, node_R, node_B).
- Consumes the judge's delete_note pulse to remove that note. Flags notes that fall off the bottom as misses. Exports per-row bitmaps to the LED matrix driver.

---
 rtl/note_pkg.sv | 31 +++
 rtl/step_divider.sv | 33 +++
 rtl/note_scroller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the falling-note lane: row codes, lane size and
// the scroller state machine encoding.
package note_pkg;

    localparam int unsigned LANE_ROWS = 8;

    // Per-row occupancy code; 2'b11 is never stored.
    localparam logic [1:0] NOTE_EMPTY = 2'b00;
    localparam logic [1:0] NOTE_RED   = 2'b01;
    localparam logic [1:0] NOTE_BLUE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Row 0 is the top of the lane, row LANE_ROWS-1 the bottom.
    typedef logic [LANE_ROWS-1:0][1:0] lane_t;

    // One bit per row, set where the row holds the given code.
    function automatic logic [LANE_ROWS-1:0] lane_mask(input lane_t lane, input logic [1:0] code);
        logic [LANE_ROWS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LANE_ROWS; i++) begin
            m[i] = (lane[i] == code);
        end
        return m;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Free-running step tick generator: one-cycle step every STEP_DIV enabled
// cycles, counter held at zero while disabled.
module step_divider #(
    parameter int unsigned STEP_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step
);

    localparam int unsigned      CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Tick on the last count, then wrap; disabled counter parks at zero.
    always_comb begin
        step    = en && (count_q == LAST);
        count_d = (!en || step) ? '0 : count_q + CNT_W'(1);
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_scroller.sv
// Single falling-note lane feeding the hit judge: accepts chart notes into a
// one-deep pending slot, scrolls them down on each step tick, reports the
// lowest note to the judge and flags notes that fall off the bottom.
module note_scroller
    import note_pkg::*;
#(
    parameter int unsigned STEP_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       spawn_valid,
    input  logic       spawn_color,
    output logic       spawn_ready,
    input  logic       delete_note,
    output logic [2:0] offset,
    output logic       node_R,
    output logic       node_B,
    output logic       miss,
    output logic       done,
    output logic [7:0] red_rows,
    output logic [7:0] blue_rows
);

    state_t     state_q;
    lane_t      lane_q;
    logic       pend_valid_q;
    logic       pend_blue_q;
    logic       miss_q;
    logic       done_q;

    logic       step;
    logic       div_en;
    logic       low_valid;
    logic [2:0] low_row;
    logic [1:0] low_code;
    logic [1:0] pend_code;
    lane_t      lane_del;
    lane_t      lane_step;
    logic       step_miss;
    logic       lane_empty;

    assign div_en = (state_q == RUN) || (state_q == DRAIN);

    step_divider #(
        .STEP_DIV(STEP_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .step(step)
    );

    // Lowest-row priority encoder: the highest-index occupied row wins.
    always_comb begin
        low_valid = 1'b0;
        low_row   = '0;
        low_code  = NOTE_EMPTY;
        for (int unsigned i = 0; i < LANE_ROWS; i++) begin
            if (lane_q[i] != NOTE_EMPTY) begin
                low_valid = 1'b1;
                low_row   = 3'(i);
                low_code  = lane_q[i];
            end
        end
    end

    // Delete first, then the miss check and shift operate on the result,
    // so a note deleted on the step edge can never be counted as a miss.
    always_comb begin
        lane_del = lane_q;
        if (delete_note && low_valid) begin
            lane_del[low_row] = NOTE_EMPTY;
        end
        pend_code  = !pend_valid_q ? NOTE_EMPTY : (pend_blue_q ? NOTE_BLUE : NOTE_RED);
        step_miss  = (lane_del[LANE_ROWS-1] != NOTE_EMPTY);
        lane_step  = {lane_del[LANE_ROWS-2:0], pend_code};
        lane_empty = (lane_q == '0);
    end

    // Scroller state machine with lane, pending slot and pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_blue_q  <= 1'b0;
            miss_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lane_q       <= '0;
                        pend_valid_q <= 1'b0;
                        state_q      <= RUN;
                    end else begin
                        lane_q <= lane_del;
                    end
                end
                RUN, DRAIN: begin
                    if (step) begin
                        lane_q       <= lane_step;
                        miss_q       <= step_miss;
                        pend_valid_q <= 1'b0;
                    end else begin
                        lane_q <= lane_del;
                    end
                    // Acceptance follows the step so a freed slot can refill.
                    if (spawn_valid && spawn_ready) begin
                        pend_valid_q <= 1'b1;
                        pend_blue_q  <= spawn_color;
                    end
                    if (state_q == RUN) begin
                        if (stop) begin
                            state_q <= DRAIN;
                        end
                    end else if (lane_empty && !pend_valid_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spawn_ready = (state_q == RUN) && !pend_valid_q;
    assign offset      = low_row;
    assign node_R      = (low_code == NOTE_RED);
    assign node_B      = (low_code == NOTE_BLUE);
    assign miss        = miss_q;
    assign done        = done_q;
    assign red_rows    = lane_mask(lane_q, NOTE_RED);
    assign blue_rows   = lane_mask(lane_q, NOTE_BLUE);

endmodule
